// File: rtl/muldiv_iter_pkg.sv
// Shared constants for the iterative multiply/divide unit: op and state encodings, default width.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
package muldiv_iter_pkg;

    localparam int MULDIV_DATA_W = 32;

    localparam logic [2:0] MULDIV_OP_MULT  = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULTU = 3'b001;
    localparam logic [2:0] MULDIV_OP_MADD  = 3'b010;
    localparam logic [2:0] MULDIV_OP_MADDU = 3'b011;
    localparam logic [2:0] MULDIV_OP_MSUB  = 3'b100;
    localparam logic [2:0] MULDIV_OP_MSUBU = 3'b101;
    localparam logic [2:0] MULDIV_OP_DIV   = 3'b110;
    localparam logic [2:0] MULDIV_OP_DIVU  = 3'b111;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_CALC = 2'd1,
        MULDIV_ACC  = 2'd2,
        MULDIV_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_is_acc(input logic [2:0] op);
        return op[2] ^ op[1];
    endfunction

    function automatic logic op_is_sub(input logic [2:0] op);
        return op[2] & ~op[1];
    endfunction

    // Even encodings are the signed variants.
    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: radix-2 shift-add, or (with MULDIV_DIV_EN) one restoring-divide step.
// Divide layout: acc HI holds the partial remainder, LO the dividend bits shifting into quotient bits.
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [2*DATA_W-1:0] mcand_i,
    input  logic                mbit_i,
`ifdef MULDIV_DIV_EN
    input  logic                is_div_i,
    input  logic [DATA_W-1:0]   divisor_i,
`endif
    output logic [2*DATA_W-1:0] acc_o
);

    logic [2*DATA_W-1:0] add_res;

    assign add_res = acc_i + (mbit_i ? mcand_i : '0);

`ifdef MULDIV_DIV_EN
    logic [DATA_W:0] rem_ext;
    logic [DATA_W:0] diff;

    // Remainder is always below the divisor, so the shifted value fits in DATA_W+1 bits.
    assign rem_ext = acc_i[2*DATA_W-1:DATA_W-1];
    assign diff    = rem_ext - {1'b0, divisor_i};

    always_comb begin
        acc_o = add_res;
        if (is_div_i) begin
            if (diff[DATA_W]) begin
                acc_o = {acc_i[2*DATA_W-2:0], 1'b0};
            end else begin
                acc_o = {diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
            end
        end
    end
`else
    assign acc_o = add_res;
`endif

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MADD/MSUB/DIV engine with start/ready handshake, pipeline stall request and flush.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise ops 110/111 complete at once with 0.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int DATA_W = MULDIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic [2*DATA_W-1:0] hilo_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                div_zero_o,
    output logic                stallreq_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    muldiv_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                is_acc_q, is_acc_d;
    logic                is_sub_q, is_sub_d;
    logic                neg_res_q, neg_res_d;
    logic                dz_q, dz_d;
    logic                calc_div;
`ifdef MULDIV_DIV_EN
    logic                is_div_q, is_div_d;
    logic                neg_rem_q, neg_rem_d;
`endif

    logic                sgn1, sgn2;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [2*DATA_W-1:0] step_acc;
    logic                done_ok;

    assign sgn1 = op_is_signed(op_i) & opdata1_i[DATA_W-1];
    assign sgn2 = op_is_signed(op_i) & opdata2_i[DATA_W-1];
    assign mag1 = sgn1 ? -opdata1_i : opdata1_i;
    assign mag2 = sgn2 ? -opdata2_i : opdata2_i;

`ifdef MULDIV_DIV_EN
    assign calc_div = is_div_q;
`else
    assign calc_div = 1'b0;
`endif

    muldiv_step #(
        .DATA_W    (DATA_W)
    ) u_step (
        .acc_i     (acc_q),
        .mcand_i   (mcand_q),
        .mbit_i    (mplier_q[0]),
`ifdef MULDIV_DIV_EN
        .is_div_i  (is_div_q),
        .divisor_i (mplier_q),
`endif
        .acc_o     (step_acc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        is_acc_d  = is_acc_q;
        is_sub_d  = is_sub_q;
        neg_res_d = neg_res_q;
        dz_d      = dz_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
`endif

        unique case (state_q)
            MULDIV_IDLE: begin
                if (start_i && !annul_i) begin
                    state_d   = MULDIV_CALC;
                    cnt_d     = '0;
                    mcand_d   = {{DATA_W{1'b0}}, mag1};
                    mplier_d  = mag2;
                    acc_d     = '0;
                    is_acc_d  = op_is_acc(op_i);
                    is_sub_d  = op_is_sub(op_i);
                    neg_res_d = sgn1 ^ sgn2;
                    dz_d      = 1'b0;
`ifdef MULDIV_DIV_EN
                    is_div_d  = op_is_div(op_i);
                    neg_rem_d = sgn1;
                    if (op_is_div(op_i)) begin
                        acc_d = {{DATA_W{1'b0}}, mag1};
                        if (opdata2_i == '0) begin
                            state_d = MULDIV_DONE;
                            acc_d   = '0;
                            dz_d    = 1'b1;
                        end
                    end
`else
                    if (op_is_div(op_i)) begin
                        state_d = MULDIV_DONE;
                    end
`endif
                end
            end
            MULDIV_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (!calc_div) begin
                    mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = is_acc_q ? MULDIV_ACC : MULDIV_DONE;
                    acc_d   = neg_res_q ? -step_acc : step_acc;
`ifdef MULDIV_DIV_EN
                    // Quotient takes the combined sign, remainder the dividend's.
                    if (is_div_q) begin
                        acc_d[DATA_W-1:0] = neg_res_q ? -step_acc[DATA_W-1:0]
                                                      : step_acc[DATA_W-1:0];
                        acc_d[2*DATA_W-1:DATA_W] = neg_rem_q ? -step_acc[2*DATA_W-1:DATA_W]
                                                             : step_acc[2*DATA_W-1:DATA_W];
                    end
`endif
                end
            end
            MULDIV_ACC: begin
                acc_d   = is_sub_q ? (hilo_i - acc_q) : (hilo_i + acc_q);
                state_d = MULDIV_DONE;
            end
            MULDIV_DONE: begin
                result_d = acc_q;
                state_d  = MULDIV_IDLE;
            end
            default: state_d = MULDIV_IDLE;
        endcase

        if (annul_i && state_q != MULDIV_IDLE) begin
            state_d  = MULDIV_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MULDIV_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            is_acc_q  <= 1'b0;
            is_sub_q  <= 1'b0;
            neg_res_q <= 1'b0;
            dz_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            is_acc_q  <= is_acc_d;
            is_sub_q  <= is_sub_d;
            neg_res_q <= neg_res_d;
            dz_q      <= dz_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // The finished value is shown during DONE itself; a flush in that cycle leaves the old result.
    assign done_ok    = (state_q == MULDIV_DONE) && !annul_i;
    assign ready_o    = done_ok;
    assign div_zero_o = done_ok & dz_q;
    assign result_o   = done_ok ? acc_q : result_q;
    assign busy_o     = (state_q != MULDIV_IDLE);
    assign stallreq_o = ((state_q == MULDIV_IDLE) && start_i && !annul_i)
                      || (state_q == MULDIV_CALC) || (state_q == MULDIV_ACC);

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised and directed scoreboard bench for muldiv_iter against a plain-arithmetic reference model.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic         annul_i = 1'b0;
    logic [2:0]   op_i = '0;
    logic [W-1:0] opdata1_i = '0;
    logic [W-1:0] opdata2_i = '0;
    logic [2*W-1:0] hilo_i = '0;
    logic [2*W-1:0] result_o;
    logic         ready_o, busy_o, div_zero_o, stallreq_o;

    int total = 0;
    int bad = 0;
    int ready_seen = 0;

    typedef struct packed {
        logic [63:0] res;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    logic [63:0] prior_res = '0;

    muldiv_iter #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hilo_i     (hilo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .div_zero_o (div_zero_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [63:0] hilo);
        exp_t e;
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = op[0] ? ua * ub : sa * sb;
        e.dz = 1'b0;
        e.res = '0;
        case (op)
            MULDIV_OP_MULT, MULDIV_OP_MULTU: e.res = p;
            MULDIV_OP_MADD, MULDIV_OP_MADDU: e.res = hilo + p;
            MULDIV_OP_MSUB, MULDIV_OP_MSUBU: e.res = hilo - p;
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 0) begin
                    e.dz = 1'b1;
                end else if (op == MULDIV_OP_DIV) begin
                    logic signed [63:0] q, r;
                    q = sa / sb;
                    r = sa % sb;
                    e.res = {r[31:0], q[31:0]};
                end else begin
                    e.res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
                end
`endif
            end
        endcase
        return e;
    endfunction

    // Edge number (after the start edge) at which DONE is entered.
    function automatic int done_edge(input logic [2:0] op, input logic [31:0] b);
        if (op == MULDIV_OP_DIV || op == MULDIV_OP_DIVU) begin
`ifdef MULDIV_DIV_EN
            return (b == 0) ? 0 : W;
`else
            return (b == b) ? 0 : 0;
`endif
        end
        if (op_is_acc(op)) return W + 1;
        return W;
    endfunction

    // Caller is positioned at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] hilo);
        exp_t e;
        int n, cyc, stalls;
        e = model(op, a, b, hilo);
        n = done_edge(op, b);
        cyc = 0;
        stalls = 1;
        op_i = op;
        opdata1_i = a;
        opdata2_i = b;
        hilo_i = hilo;
        start_i = 1'b1;
        exp_q.push_back(e);
        #1;
        check($sformatf("stall_start op%0d", op), {63'b0, stallreq_o}, 64'd1);
        @(posedge clk);
        #1 start_i = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ready_o) break;
            if (stallreq_o) stalls++;
        end
        $display("op=%0d a=%h b=%h hilo=%h -> result=%h dz=%0d cycles=%0d",
                 op, a, b, hilo, result_o, div_zero_o, cyc);
        check($sformatf("latency op%0d", op), 64'(cyc), 64'(n + 1));
        check($sformatf("stall_cycles op%0d", op), 64'(stalls), 64'(n + 1));
        check($sformatf("stall_done op%0d", op), {63'b0, stallreq_o}, 64'd0);
        @(negedge clk);
        check($sformatf("result_hold op%0d", op), result_o, e.res);
        check($sformatf("busy_after op%0d", op), {63'b0, busy_o}, 64'd0);
        prior_res = e.res;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " result"}, result_o, 64'd0);
        check({tag, " flags"}, {59'b0, ready_o, busy_o, div_zero_o, stallreq_o, 1'b0}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ready_o) begin
            ready_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got result %h expected no ready", result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result_o, e.res);
                check("div_zero", {63'b0, div_zero_o}, {63'b0, e.dz});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "timeout");
    end

    initial begin
        int seen_before;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        run_op(MULDIV_OP_MULT,  32'hFFFFFFFE, 32'h00000003, 64'h0);
        run_op(MULDIV_OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000001_00000000);
        run_op(MULDIV_OP_MSUB,  32'd2, 32'd3, 64'h0);
        run_op(MULDIV_OP_MSUB,  32'd2, 32'd3, 64'h00000000_00000010);
        run_op(MULDIV_OP_DIV,   32'hFFFFFFF9, 32'd2, 64'h0);
        run_op(MULDIV_OP_DIVU,  32'd7, 32'd2, 64'h0);
        run_op(MULDIV_OP_DIVU,  32'd5, 32'd0, 64'h0);
        run_op(MULDIV_OP_MULTU, 32'd1000, 32'd2000, 64'h0);

        // Flush a MULT at edge 10.
        seen_before = ready_seen;
        op_i = MULDIV_OP_MULT; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) annul_i = 1'b1;
        @(posedge clk);
        #1 annul_i = 1'b0;
        check("annul_busy", {63'b0, busy_o}, 64'd0);
        check("annul_result", result_o, prior_res);
        repeat (40) @(negedge clk);
        check("annul_no_ready", 64'(ready_seen - seen_before), 64'd0);
        $display("annul at edge 10: busy=%0d result=%h", busy_o, result_o);

        // Asynchronous reset at edge 20 of a MULT.
        op_i = MULDIV_OP_MULT; opdata1_i = 32'd5; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        $display("reset at edge 20: result=%h busy=%0d", result_o, busy_o);
        @(negedge clk) rst_n = 1'b1;
        run_op(MULDIV_OP_MULTU, 32'd3, 32'd4, 64'h0);
        check("after_reset_value", prior_res, 64'h0000_0000_0000_000C);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'd0;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, ra, rb, {$urandom, $urandom});
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
